// File: rtl/proc_io_bank_if.sv
`default_nettype none
// ============================================================================
// Module   : proc_io_bank_if
// Purpose  : Core/external-side bundle for proc_io_bank (sample inputs,
//            core read/write ports, output holding regs, flags, interrupt).
// Revision : 1.0
// ============================================================================
interface proc_io_bank_if #(
   parameter int NUBITS = 32,
   parameter int NUIOIN = 2,
   parameter int NUIOOU = 2,
   parameter int AIW    = (NUIOIN > 1) ? $clog2(NUIOIN) : 1,
   parameter int AOW    = (NUIOOU > 1) ? $clog2(NUIOOU) : 1
);
   logic [NUIOIN*NUBITS-1:0] ext_in_data;
   logic [NUIOIN-1:0]        ext_in_vld;
   logic [NUIOIN-1:0]        ext_in_rdy;
   logic [NUBITS-1:0]        proc_in;
   logic [AIW-1:0]           proc_addr_in;
   logic                     proc_req_in;
   logic [NUBITS-1:0]        proc_out;
   logic [AOW-1:0]           proc_addr_out;
   logic                     proc_out_en;
   logic [NUIOOU*NUBITS-1:0] ext_out_data;
   logic [NUIOOU-1:0]        ext_out_en;
   logic                     itr;
   logic [NUIOIN-1:0]        ovf_flag;
   logic [NUIOIN-1:0]        unf_flag;
   logic                     flag_clr;

   modport master (
      output ext_in_data, ext_in_vld, proc_addr_in, proc_req_in,
             proc_out, proc_addr_out, proc_out_en, flag_clr,
      input  ext_in_rdy, proc_in, ext_out_data, ext_out_en, itr,
             ovf_flag, unf_flag
   );

   modport slave (
      input  ext_in_data, ext_in_vld, proc_addr_in, proc_req_in,
             proc_out, proc_addr_out, proc_out_en, flag_clr,
      output ext_in_rdy, proc_in, ext_out_data, ext_out_en, itr,
             ovf_flag, unf_flag
   );
endinterface
`default_nettype wire

// File: rtl/proc_io_bank.sv
`default_nettype none
// ============================================================================
// Module   : proc_io_bank
// Purpose  : Multi-channel I/O front end for the proc_fl core: per-channel
//            input FIFOs, registered output holding regs with strobes,
//            sticky overflow/underflow flags and a data-pending interrupt.
// Revision : 1.0
// ============================================================================
module proc_io_bank #(
   parameter int                NUBITS = 32,
   parameter int                NUIOIN = 2,
   parameter int                NUIOOU = 2,
   parameter int                FDEPTH = 4,
   parameter logic [NUIOIN-1:0] ITRMSK = '1,
   parameter int                AIW    = (NUIOIN > 1) ? $clog2(NUIOIN) : 1,
   parameter int                AOW    = (NUIOOU > 1) ? $clog2(NUIOOU) : 1
) (
   input wire logic      clk,
   input wire logic      rst,
   proc_io_bank_if.slave bus
);
   localparam int             PW     = $clog2(FDEPTH);
   localparam int             CW     = PW + 1;
   localparam logic [CW-1:0]  C_FULL = CW'(FDEPTH);

   logic [NUIOIN-1:0] sel_w;
   logic [NUIOIN-1:0] push_w;
   logic [NUIOIN-1:0] pop_w;
   logic [NUIOIN-1:0] nonempty_w;
   logic [NUIOIN-1:0] full_w;
   logic [NUIOIN-1:0] rdy_w;
   logic [NUBITS-1:0] head_w [NUIOIN];

   generate
      for (genvar i = 0; i < NUIOIN; i++) begin : g_fifo
         logic [NUBITS-1:0] mem_q [FDEPTH];
         logic [PW-1:0]     wr_ptr_q;
         logic [PW-1:0]     rd_ptr_q;
         logic [CW-1:0]     cnt_q;
         logic [CW-1:0]     cnt_d;
         logic              rdy_q;

         assign sel_w[i]      = bus.proc_req_in && (bus.proc_addr_in == AIW'(i));
         assign full_w[i]     = (cnt_q == C_FULL);
         assign nonempty_w[i] = (cnt_q != '0);
         assign push_w[i]     = bus.ext_in_vld[i] && rdy_q;
         assign pop_w[i]      = sel_w[i] && nonempty_w[i];
         assign head_w[i]     = mem_q[rd_ptr_q];
         assign rdy_w[i]      = rdy_q;

         always_comb begin
            cnt_d = cnt_q;
            case ({push_w[i], pop_w[i]})
               2'b10:   cnt_d = cnt_q + CW'(1);
               2'b01:   cnt_d = cnt_q - CW'(1);
               default: cnt_d = cnt_q;
            endcase
         end

         // Ready is registered from next occupancy so it never sees a same-cycle pop.
         always_ff @(posedge clk) begin
            if (rst) begin
               wr_ptr_q <= '0;
               rd_ptr_q <= '0;
               cnt_q    <= '0;
               rdy_q    <= 1'b0;
            end else begin
               if (push_w[i]) wr_ptr_q <= wr_ptr_q + PW'(1);
               if (pop_w[i])  rd_ptr_q <= rd_ptr_q + PW'(1);
               cnt_q <= cnt_d;
               rdy_q <= (cnt_d != C_FULL);
            end
         end

         always_ff @(posedge clk) begin
            if (push_w[i]) mem_q[wr_ptr_q] <= bus.ext_in_data[i*NUBITS +: NUBITS];
         end
      end
   endgenerate

   logic [NUBITS-1:0]        proc_in_q,  proc_in_d;
   logic [NUIOOU*NUBITS-1:0] out_data_q, out_data_d;
   logic [NUIOOU-1:0]        out_en_q,   out_en_d;
   logic [NUIOIN-1:0]        ovf_q,      ovf_d;
   logic [NUIOIN-1:0]        unf_q,      unf_d;
   logic                     pend_w, pend_q, itr_q, itr_d;
   logic                     addr_in_ok_w;

   assign addr_in_ok_w = (32'(bus.proc_addr_in) < NUIOIN);
   assign pend_w       = |(nonempty_w & ITRMSK);
   assign itr_d        = pend_w && !pend_q;

   always_comb begin
      proc_in_d = proc_in_q;
      if (bus.proc_req_in) begin
         if (!addr_in_ok_w) begin
            proc_in_d = '0;
         end else begin
            for (int i = 0; i < NUIOIN; i++) begin
               if (pop_w[i]) proc_in_d = head_w[i];
            end
         end
      end
   end

   always_comb begin
      out_en_d   = '0;
      out_data_d = out_data_q;
      for (int j = 0; j < NUIOOU; j++) begin
         if (bus.proc_out_en && (bus.proc_addr_out == AOW'(j))) begin
            out_en_d[j]                    = 1'b1;
            out_data_d[j*NUBITS +: NUBITS] = bus.proc_out;
         end
      end
   end

   // A set event in the clearing cycle survives the clear.
   always_comb begin
      ovf_d = (ovf_q & ~{NUIOIN{bus.flag_clr}}) | (bus.ext_in_vld & full_w);
      unf_d = (unf_q & ~{NUIOIN{bus.flag_clr}}) | (sel_w & ~nonempty_w);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         proc_in_q  <= '0;
         out_data_q <= '0;
         out_en_q   <= '0;
         ovf_q      <= '0;
         unf_q      <= '0;
         pend_q     <= 1'b0;
         itr_q      <= 1'b0;
      end else begin
         proc_in_q  <= proc_in_d;
         out_data_q <= out_data_d;
         out_en_q   <= out_en_d;
         ovf_q      <= ovf_d;
         unf_q      <= unf_d;
         pend_q     <= pend_w;
         itr_q      <= itr_d;
      end
   end

   assign bus.ext_in_rdy   = rdy_w;
   assign bus.proc_in      = proc_in_q;
   assign bus.ext_out_data = out_data_q;
   assign bus.ext_out_en   = out_en_q;
   assign bus.itr          = itr_q;
   assign bus.ovf_flag     = ovf_q;
   assign bus.unf_flag     = unf_q;
endmodule
`default_nettype wire

// File: tb/tb_proc_io_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_proc_io_bank
// Purpose  : Self-checking bench for proc_io_bank: directed vector table,
//            interrupt/reset sequences, single-channel build, random vs model.
// Revision : 1.0
// ============================================================================
module tb_proc_io_bank;
   localparam int             FD   = 4;
   localparam logic [2:0]     MASK = 3'b001;
   localparam logic [95:0]    O0   = '0;
   localparam logic [95:0]    O1   = 96'h00000000_DEADBEEF_00000000;
   localparam logic [95:0]    O2   = 96'h00000000_DEADBEEF_CAFEF00D;
   localparam logic [95:0]    O3   = 96'h00000000_DEADBEEF_0BADF00D;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   proc_io_bank_if #(.NUBITS(32), .NUIOIN(3), .NUIOOU(3)) bus_a ();
   proc_io_bank_if #(.NUBITS(8),  .NUIOIN(1), .NUIOOU(1)) bus_b ();

   proc_io_bank #(.NUBITS(32), .NUIOIN(3), .NUIOOU(3), .FDEPTH(FD), .ITRMSK(MASK))
      u_dut_a (.clk(clk), .rst(rst), .bus(bus_a));
   proc_io_bank #(.NUBITS(8), .NUIOIN(1), .NUIOOU(1), .FDEPTH(2))
      u_dut_b (.clk(clk), .rst(rst), .bus(bus_b));

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic cyc_a(input logic [2:0] vld, input logic [95:0] din, input logic req,
                        input logic [1:0] ain, input logic wen, input logic [1:0] aout,
                        input logic [31:0] dout, input logic clr, input logic r);
      bus_a.ext_in_vld    = vld;
      bus_a.ext_in_data   = din;
      bus_a.proc_req_in   = req;
      bus_a.proc_addr_in  = ain;
      bus_a.proc_out_en   = wen;
      bus_a.proc_addr_out = aout;
      bus_a.proc_out      = dout;
      bus_a.flag_clr      = clr;
      rst                 = r;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_a(input logic r);
      cyc_a(3'b000, '0, 1'b0, 2'd0, 1'b0, 2'd0, 32'h0, 1'b0, r);
   endtask

   task automatic cyc_b(input logic vld, input logic [7:0] din, input logic req, input logic ain,
                        input logic wen, input logic aout, input logic [7:0] dout);
      bus_b.ext_in_vld    = vld;
      bus_b.ext_in_data   = din;
      bus_b.proc_req_in   = req;
      bus_b.proc_addr_in  = ain;
      bus_b.proc_out_en   = wen;
      bus_b.proc_addr_out = aout;
      bus_b.proc_out      = dout;
      bus_b.flag_clr      = 1'b0;
      rst                 = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic check_a(input string tag, input logic [2:0] rdy, input logic [31:0] pin,
                          input logic [2:0] oen, input logic [95:0] odata, input logic itr,
                          input logic [2:0] ovf, input logic [2:0] unf);
      chk({tag, " rdy"},   bus_a.ext_in_rdy,   rdy);
      chk({tag, " pin"},   bus_a.proc_in,      pin);
      chk({tag, " oen"},   bus_a.ext_out_en,   oen);
      chk({tag, " odata"}, bus_a.ext_out_data, odata);
      chk({tag, " itr"},   bus_a.itr,          itr);
      chk({tag, " ovf"},   bus_a.ovf_flag,     ovf);
      chk({tag, " unf"},   bus_a.unf_flag,     unf);
   endtask

   // Behavioural reference: one queue per channel, flags and strobes by rule.
   typedef logic [31:0] word_q_t[$];
   word_q_t     mq [3];
   logic [31:0] m_pin;
   logic [95:0] m_odata;
   logic [2:0]  m_oen, m_ovf, m_unf, m_rdy;
   logic        m_itr, m_pend_prev;

   task automatic model_step(input logic [2:0] vld, input logic [95:0] din, input logic req,
                             input logic [1:0] ain, input logic wen, input logic [1:0] aout,
                             input logic [31:0] dout, input logic clr, input logic r);
      logic [2:0] push, ovf_set, unf_set;
      logic       pend;
      if (r) begin
         for (int i = 0; i < 3; i++) mq[i].delete();
         m_pin = '0; m_odata = '0; m_oen = '0; m_ovf = '0; m_unf = '0; m_rdy = '0;
         m_itr = 1'b0; m_pend_prev = 1'b0;
         return;
      end
      push = '0; ovf_set = '0; unf_set = '0; pend = 1'b0;
      for (int i = 0; i < 3; i++) begin
         if (vld[i] && m_rdy[i]) push[i] = 1'b1;
         if (vld[i] && mq[i].size() == FD) ovf_set[i] = 1'b1;
         if (MASK[i] && mq[i].size() != 0) pend = 1'b1;
      end
      m_itr       = pend && !m_pend_prev;
      m_pend_prev = pend;
      if (req) begin
         if (ain < 2'd3) begin
            if (mq[ain].size() > 0) m_pin = mq[ain].pop_front();
            else unf_set[ain] = 1'b1;
         end else begin
            m_pin = '0;
         end
      end
      for (int i = 0; i < 3; i++) if (push[i]) mq[i].push_back(din[i*32 +: 32]);
      m_ovf = (clr ? 3'b000 : m_ovf) | ovf_set;
      m_unf = (clr ? 3'b000 : m_unf) | unf_set;
      m_oen = '0;
      if (wen && aout < 2'd3) begin
         m_oen[aout]            = 1'b1;
         m_odata[aout*32 +: 32] = dout;
      end
      for (int i = 0; i < 3; i++) m_rdy[i] = (mq[i].size() < FD);
   endtask

   typedef struct {
      logic [2:0]  vld;  logic [31:0] din;  logic req;  logic [1:0] ain;
      logic        wen;  logic [1:0]  aout; logic [31:0] dout; logic clr;
      logic [2:0]  rdy;  logic [31:0] pin;  logic [2:0] oen; logic [95:0] odata;
      logic [2:0]  ovf;  logic [2:0]  unf;
   } vec_t;
   vec_t tbl[$];

   function automatic vec_t mk(input logic [2:0] vld, input logic [31:0] din, input logic req,
                               input logic [1:0] ain, input logic wen, input logic [1:0] aout,
                               input logic [31:0] dout, input logic clr, input logic [2:0] rdy,
                               input logic [31:0] pin, input logic [2:0] oen,
                               input logic [95:0] odata, input logic [2:0] ovf,
                               input logic [2:0] unf);
      vec_t v;
      v.vld = vld; v.din = din; v.req = req; v.ain = ain; v.wen = wen; v.aout = aout;
      v.dout = dout; v.clr = clr; v.rdy = rdy; v.pin = pin; v.oen = oen; v.odata = odata;
      v.ovf = ovf; v.unf = unf;
      return v;
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, got timeout required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus_b.ext_in_vld = 1'b0; bus_b.ext_in_data = '0; bus_b.proc_req_in = 1'b0;
      bus_b.proc_addr_in = 1'b0; bus_b.proc_out_en = 1'b0; bus_b.proc_addr_out = 1'b0;
      bus_b.proc_out = '0; bus_b.flag_clr = 1'b0;
      idle_a(1'b1);
      idle_a(1'b1);
      check_a("reset", 3'b000, 32'h0, 3'b000, O0, 1'b0, 3'b000, 3'b000);
      chk("b reset rdy", bus_b.ext_in_rdy, 1'b0);

      // Single-channel build, FDEPTH=2, AIW=AOW=1.
      cyc_b(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00); chk("b idle rdy",  bus_b.ext_in_rdy, 1'b1);
      cyc_b(1'b1, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00); chk("b push1 rdy", bus_b.ext_in_rdy, 1'b1);
      cyc_b(1'b1, 8'h6B, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00); chk("b full rdy",  bus_b.ext_in_rdy, 1'b0);
      chk("b itr pulse", bus_b.itr, 1'b1);
      cyc_b(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00); chk("b read pin",  bus_b.proc_in, 8'h5A);
      chk("b itr once", bus_b.itr, 1'b0);
      chk("b pop rdy", bus_b.ext_in_rdy, 1'b1);
      cyc_b(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00); chk("b oor pin",   bus_b.proc_in, 8'h00);
      cyc_b(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'hC3); chk("b wr oen",    bus_b.ext_out_en, 1'b1);
      chk("b wr data", bus_b.ext_out_data, 8'hC3);
      cyc_b(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 8'h99); chk("b oor oen",   bus_b.ext_out_en, 1'b0);
      chk("b oor data", bus_b.ext_out_data, 8'hC3);
      cyc_b(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);

      // Directed table on the 3-channel build.
      tbl.push_back(mk(3'b000, 32'h00, 1'b0, 2'd0, 1'b0, 2'd0, 32'h0,        1'b0, 3'b111, 32'h00, 3'b000, O0, 3'b000, 3'b000));
      tbl.push_back(mk(3'b001, 32'h11, 1'b0, 2'd0, 1'b0, 2'd0, 32'h0,        1'b0, 3'b111, 32'h00, 3'b000, O0, 3'b000, 3'b000));
      tbl.push_back(mk(3'b001, 32'h22, 1'b0, 2'd0, 1'b0, 2'd0, 32'h0,        1'b0, 3'b111, 32'h00, 3'b000, O0, 3'b000, 3'b000));
      tbl.push_back(mk(3'b001, 32'h33, 1'b0, 2'd0, 1'b0, 2'd0, 32'h0,        1'b0, 3'b111, 32'h00, 3'b000, O0, 3'b000, 3'b000));
      tbl.push_back(mk(3'b000, 32'h00, 1'b1, 2'd0, 1'b0, 2'd0, 32'h0,        1'b0, 3'b111, 32'h11, 3'b000, O0, 3'b000, 3'b000));
      tbl.push_back(mk(3'b000, 32'h00, 1'b1, 2'd0, 1'b0, 2'd0, 32'h0,        1'b0, 3'b111, 32'h22, 3'b000, O0, 3'b000, 3'b000));
      tbl.push_back(mk(3'b000, 32'h00, 1'b1, 2'd0, 1'b0, 2'd0, 32'h0,        1'b0, 3'b111, 32'h33, 3'b000, O0, 3'b000, 3'b000));
      tbl.push_back(mk(3'b000, 32'h00, 1'b1, 2'd0, 1'b0, 2'd0, 32'h0,        1'b0, 3'b111, 32'h33, 3'b000, O0, 3'b000, 3'b001));
      tbl.push_back(mk(3'b000, 32'h00, 1'b1, 2'd3, 1'b0, 2'd0, 32'h0,        1'b0, 3'b111, 32'h00, 3'b000, O0, 3'b000, 3'b001));
      tbl.push_back(mk(3'b000, 32'h00, 1'b0, 2'd0, 1'b0, 2'd0, 32'h0,        1'b1, 3'b111, 32'h00, 3'b000, O0, 3'b000, 3'b000));
      tbl.push_back(mk(3'b010, 32'hA1, 1'b0, 2'd0, 1'b0, 2'd0, 32'h0,        1'b0, 3'b111, 32'h00, 3'b000, O0, 3'b000, 3'b000));
      tbl.push_back(mk(3'b010, 32'hA2, 1'b0, 2'd0, 1'b0, 2'd0, 32'h0,        1'b0, 3'b111, 32'h00, 3'b000, O0, 3'b000, 3'b000));
      tbl.push_back(mk(3'b010, 32'hA3, 1'b0, 2'd0, 1'b0, 2'd0, 32'h0,        1'b0, 3'b111, 32'h00, 3'b000, O0, 3'b000, 3'b000));
      tbl.push_back(mk(3'b010, 32'hA4, 1'b0, 2'd0, 1'b0, 2'd0, 32'h0,        1'b0, 3'b101, 32'h00, 3'b000, O0, 3'b000, 3'b000));
      tbl.push_back(mk(3'b010, 32'hA5, 1'b0, 2'd0, 1'b0, 2'd0, 32'h0,        1'b0, 3'b101, 32'h00, 3'b000, O0, 3'b010, 3'b000));
      tbl.push_back(mk(3'b000, 32'h00, 1'b0, 2'd0, 1'b0, 2'd0, 32'h0,        1'b1, 3'b101, 32'h00, 3'b000, O0, 3'b000, 3'b000));
      tbl.push_back(mk(3'b010, 32'hA6, 1'b0, 2'd0, 1'b0, 2'd0, 32'h0,        1'b1, 3'b101, 32'h00, 3'b000, O0, 3'b010, 3'b000));
      tbl.push_back(mk(3'b000, 32'h00, 1'b0, 2'd0, 1'b0, 2'd0, 32'h0,        1'b0, 3'b101, 32'h00, 3'b000, O0, 3'b010, 3'b000));
      tbl.push_back(mk(3'b000, 32'h00, 1'b1, 2'd1, 1'b0, 2'd0, 32'h0,        1'b0, 3'b111, 32'hA1, 3'b000, O0, 3'b010, 3'b000));
      tbl.push_back(mk(3'b000, 32'h00, 1'b1, 2'd1, 1'b0, 2'd0, 32'h0,        1'b0, 3'b111, 32'hA2, 3'b000, O0, 3'b010, 3'b000));
      tbl.push_back(mk(3'b000, 32'h00, 1'b1, 2'd1, 1'b0, 2'd0, 32'h0,        1'b0, 3'b111, 32'hA3, 3'b000, O0, 3'b010, 3'b000));
      tbl.push_back(mk(3'b000, 32'h00, 1'b1, 2'd1, 1'b0, 2'd0, 32'h0,        1'b0, 3'b111, 32'hA4, 3'b000, O0, 3'b010, 3'b000));
      tbl.push_back(mk(3'b000, 32'h00, 1'b1, 2'd1, 1'b0, 2'd0, 32'h0,        1'b0, 3'b111, 32'hA4, 3'b000, O0, 3'b010, 3'b010));
      tbl.push_back(mk(3'b000, 32'h00, 1'b0, 2'd0, 1'b1, 2'd1, 32'hDEADBEEF, 1'b0, 3'b111, 32'hA4, 3'b010, O1, 3'b010, 3'b010));
      tbl.push_back(mk(3'b000, 32'h00, 1'b0, 2'd0, 1'b0, 2'd0, 32'h0,        1'b0, 3'b111, 32'hA4, 3'b000, O1, 3'b010, 3'b010));
      tbl.push_back(mk(3'b000, 32'h00, 1'b0, 2'd0, 1'b1, 2'd3, 32'h12345678, 1'b0, 3'b111, 32'hA4, 3'b000, O1, 3'b010, 3'b010));
      tbl.push_back(mk(3'b000, 32'h00, 1'b0, 2'd0, 1'b1, 2'd0, 32'hCAFEF00D, 1'b0, 3'b111, 32'hA4, 3'b001, O2, 3'b010, 3'b010));
      tbl.push_back(mk(3'b000, 32'h00, 1'b0, 2'd0, 1'b1, 2'd0, 32'h0BADF00D, 1'b0, 3'b111, 32'hA4, 3'b001, O3, 3'b010, 3'b010));
      tbl.push_back(mk(3'b000, 32'h00, 1'b0, 2'd0, 1'b0, 2'd0, 32'h0,        1'b0, 3'b111, 32'hA4, 3'b000, O3, 3'b010, 3'b010));
      tbl.push_back(mk(3'b100, 32'h77, 1'b0, 2'd0, 1'b0, 2'd0, 32'h0,        1'b0, 3'b111, 32'hA4, 3'b000, O3, 3'b010, 3'b010));
      tbl.push_back(mk(3'b100, 32'h88, 1'b1, 2'd2, 1'b0, 2'd0, 32'h0,        1'b0, 3'b111, 32'h77, 3'b000, O3, 3'b010, 3'b010));
      tbl.push_back(mk(3'b000, 32'h00, 1'b1, 2'd2, 1'b0, 2'd0, 32'h0,        1'b0, 3'b111, 32'h88, 3'b000, O3, 3'b010, 3'b010));
      tbl.push_back(mk(3'b000, 32'h00, 1'b1, 2'd2, 1'b0, 2'd0, 32'h0,        1'b0, 3'b111, 32'h88, 3'b000, O3, 3'b010, 3'b110));
      tbl.push_back(mk(3'b100, 32'h99, 1'b1, 2'd2, 1'b0, 2'd0, 32'h0,        1'b0, 3'b111, 32'h88, 3'b000, O3, 3'b010, 3'b110));
      tbl.push_back(mk(3'b000, 32'h00, 1'b1, 2'd2, 1'b0, 2'd0, 32'h0,        1'b0, 3'b111, 32'h99, 3'b000, O3, 3'b010, 3'b110));

      foreach (tbl[k]) begin
         cyc_a(tbl[k].vld, {3{tbl[k].din}}, tbl[k].req, tbl[k].ain, tbl[k].wen, tbl[k].aout,
               tbl[k].dout, tbl[k].clr, 1'b0);
         chk($sformatf("row%0d rdy", k),   bus_a.ext_in_rdy,   tbl[k].rdy);
         chk($sformatf("row%0d pin", k),   bus_a.proc_in,      tbl[k].pin);
         chk($sformatf("row%0d oen", k),   bus_a.ext_out_en,   tbl[k].oen);
         chk($sformatf("row%0d odata", k), bus_a.ext_out_data, tbl[k].odata);
         chk($sformatf("row%0d ovf", k),   bus_a.ovf_flag,     tbl[k].ovf);
         chk($sformatf("row%0d unf", k),   bus_a.unf_flag,     tbl[k].unf);
      end

      // Interrupt edge behaviour: only ch0 is unmasked.
      idle_a(1'b1);
      idle_a(1'b0);
      for (int k = 0; k < 3; k++) begin
         cyc_a(3'b010, {3{32'h5}}, 1'b0, 2'd0, 1'b0, 2'd0, 32'h0, 1'b0, 1'b0);
         chk($sformatf("itr masked ch1 %0d", k), bus_a.itr, 1'b0);
      end
      cyc_a(3'b001, {3{32'h1}}, 1'b0, 2'd0, 1'b0, 2'd0, 32'h0, 1'b0, 1'b0); chk("itr push0 e1", bus_a.itr, 1'b0);
      idle_a(1'b0);                                                         chk("itr pulse",    bus_a.itr, 1'b1);
      cyc_a(3'b001, {3{32'h2}}, 1'b0, 2'd0, 1'b0, 2'd0, 32'h0, 1'b0, 1'b0); chk("itr 2nd push", bus_a.itr, 1'b0);
      idle_a(1'b0);                                                         chk("itr no repulse", bus_a.itr, 1'b0);
      cyc_a(3'b000, '0, 1'b1, 2'd0, 1'b0, 2'd0, 32'h0, 1'b0, 1'b0);         chk("itr drain1",   bus_a.itr, 1'b0);
      cyc_a(3'b000, '0, 1'b1, 2'd0, 1'b0, 2'd0, 32'h0, 1'b0, 1'b0);         chk("itr drain2",   bus_a.itr, 1'b0);
      idle_a(1'b0);                                                         chk("itr empty",    bus_a.itr, 1'b0);
      cyc_a(3'b001, {3{32'h3}}, 1'b0, 2'd0, 1'b0, 2'd0, 32'h0, 1'b0, 1'b0); chk("itr refill",   bus_a.itr, 1'b0);
      idle_a(1'b0);                                                         chk("itr new pulse", bus_a.itr, 1'b1);
      idle_a(1'b0);                                                         chk("itr pulse end", bus_a.itr, 1'b0);

      // Reset mid-stream: queued data, a pending strobe and a pending itr all vanish.
      idle_a(1'b1);
      idle_a(1'b0);
      cyc_a(3'b001, {3{32'h55}}, 1'b0, 2'd0, 1'b0, 2'd0, 32'h0, 1'b0, 1'b0);
      cyc_a(3'b001, {3{32'h66}}, 1'b0, 2'd0, 1'b1, 2'd1, 32'hFEEDFACE, 1'b0, 1'b1);
      check_a("midrst", 3'b000, 32'h0, 3'b000, O0, 1'b0, 3'b000, 3'b000);
      idle_a(1'b0);
      check_a("postrst", 3'b111, 32'h0, 3'b000, O0, 1'b0, 3'b000, 3'b000);
      cyc_a(3'b000, '0, 1'b1, 2'd0, 1'b0, 2'd0, 32'h0, 1'b0, 1'b0);
      check_a("postrst read", 3'b111, 32'h0, 3'b000, O0, 1'b0, 3'b000, 3'b001);
      idle_a(1'b0);
      chk("postrst itr", bus_a.itr, 1'b0);

      // Random traffic against the queue model.
      idle_a(1'b1);
      model_step(3'b000, '0, 1'b0, 2'd0, 1'b0, 2'd0, 32'h0, 1'b0, 1'b1);
      for (int n = 0; n < 400; n++) begin
         logic [2:0]  vld;
         logic [95:0] din;
         logic        req, wen, clr, r;
         logic [1:0]  ain, aout;
         logic [31:0] dout;
         for (int i = 0; i < 3; i++) vld[i] = ($urandom_range(0, 2) == 0);
         din  = {$urandom, $urandom, $urandom};
         req  = ($urandom_range(0, 3) != 0);
         ain  = 2'($urandom_range(0, 3));
         wen  = ($urandom_range(0, 2) == 0);
         aout = 2'($urandom_range(0, 3));
         dout = $urandom;
         clr  = ($urandom_range(0, 15) == 0);
         r    = ($urandom_range(0, 79) == 0);
         cyc_a(vld, din, req, ain, wen, aout, dout, clr, r);
         model_step(vld, din, req, ain, wen, aout, dout, clr, r);
         check_a($sformatf("rnd%0d", n), m_rdy, m_pin, m_oen, m_odata, m_itr, m_ovf, m_unf);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/proc_io_bank.md
Name: proc_io_bank

Overview:
- Parametrised multi-channel I/O front end between a proc_fl core and external sample sources and sinks.
- Replaces the per-project glue that drove a bare request strobe and a combinational output address decoder.
- Adds per-input-channel sample FIFOs with ready/valid backpressure, registered per-channel output holding registers with write strobes, sticky overflow/underflow flags, and a maskable data-pending interrupt into the core's itr input.
- Data is carried raw. int2float/float2int conversion stays in the project top level.

Parameters:
NUBITS, 32, data word width on both sides
NUIOIN, 2, number of input channels (>=1)
NUIOOU, 2, number of output channels (>=1)
FDEPTH, 4, input FIFO depth per channel; power of 2, >=2
ITRMSK, all ones (NUIOIN bits), channel i contributes to the interrupt when ITRMSK[i]=1
AIW, max(1,clog2(NUIOIN)), input address width; minimum 1 so single-channel builds get no zero/negative range
AOW, max(1,clog2(NUIOOU)), output address width; same minimum-1 rule

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
ext_in_data  in  NUIOIN*NUBITS  channel i at bits [i*NUBITS +: NUBITS]
ext_in_vld  in  NUIOIN  sample valid per channel
ext_in_rdy  out  NUIOIN  FIFO not full per channel
proc_in  out  NUBITS  registered read data to core
proc_addr_in  in  AIW  input channel select
proc_req_in  in  1  core read strobe
proc_out  in  NUBITS  core write data
proc_addr_out  in  AOW  output channel select
proc_out_en  in  1  core write strobe
ext_out_data  out  NUIOOU*NUBITS  per-channel holding registers
ext_out_en  out  NUIOOU  one-cycle update strobe per channel
itr  out  1  interrupt pulse to core
ovf_flag  out  NUIOIN  sticky overflow per input channel
unf_flag  out  NUIOIN  sticky underflow per input channel
flag_clr  in  1  clears all sticky flags

Behaviour:
- Reset: every output is 0 while rst=1; FIFOs are emptied (pointers and counts to 0).
  - ext_in_rdy is forced 0 during reset.
  - ext_in_rdy returns to all-ones the cycle after rst deasserts.
- Input FIFO, per channel: ext_in_rdy[i] = !full[i] (registered occupancy; does not depend on same-cycle pop).
  - Push when ext_in_vld[i] && ext_in_rdy[i].
  - ext_in_vld[i] && full[i]: sample dropped, ovf_flag[i] set.
  - Pointers wrap modulo FDEPTH. Count ranges 0..FDEPTH.
- Core read, 1-cycle latency: on proc_req_in with addr a < NUIOIN:
  - FIFO a non-empty: proc_in <= head of FIFO a on the next edge, and the entry is popped.
  - FIFO a empty: proc_in holds its previous value, unf_flag[a] is set, and nothing is popped.
  - A push to the same empty FIFO in that same cycle does not satisfy the read; the sample is stored.
  - a >= NUIOIN: proc_in <= 0, no pop, no flag change.
- Simultaneous push and pop on a non-full, non-empty FIFO: count unchanged, both pointers advance.
- Core write: on proc_out_en with addr b < NUIOOU:
  - ext_out_data channel b <= proc_out on the next edge.
  - ext_out_en[b]=1 for exactly that following cycle; all other strobe bits 0.
  - Other channels hold their values.
  - b >= NUIOOU: write ignored.
  - Back-to-back writes to the same channel give consecutive strobes and the last value wins.
- Interrupt: pend = |(nonempty & ITRMSK), registered as pend_q.
  - itr = pend && !pend_q, registered: a one-cycle pulse on each 0->1 transition of pend.
  - No re-pulse while any masked channel stays non-empty.
- Flags: flag_clr zeroes both flag vectors. A set event in the same cycle as flag_clr wins (flag reads 1 afterwards).
- Reset mid-operation: all queued samples are lost, no ext_out_en strobe is emitted, and any pending itr is cancelled.
- No combinational path from proc_req_in or proc_out_en to any output.

Test Plan:
- NUIOIN=2, FDEPTH=4: push 0x11,0x22,0x33 on ch0, then req with addr 0 three times -> proc_in = 0x11, 0x22, 0x33, each one cycle after its req; unf_flag=0.
- Push 5 samples on ch1 with vld held high -> ext_in_rdy[1] falls after the 4th push; 5th sample dropped, ovf_flag[1]=1. flag_clr -> 0. flag_clr in the same cycle as a further overflow -> flag stays 1.
- Req on empty ch0 after proc_in=0x33 -> proc_in stays 0x33, unf_flag[0]=1. Req with addr=2 (NUIOIN=2, AIW=1 so use NUIOIN=3, addr 3 with AIW=2) -> proc_in=0.
- proc_out=0xDEADBEEF, addr_out=1, en pulse -> next cycle ext_out_data ch1=0xDEADBEEF, ext_out_en=2'b10 for 1 cycle, ch0 unchanged. addr_out out of range -> no strobe.
- ITRMSK=2'b01: push to ch1 only -> itr stays 0. Push to ch0 -> single itr pulse; second ch0 push -> no pulse. Drain ch0 then push again -> new pulse.
- Fill ch0 with 2 samples, assert rst one cycle mid-stream -> all outputs 0, FIFO empty (next req sets unf_flag). Build with NUIOIN=1, NUIOOU=1 elaborates with AIW=AOW=1.
